// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, schedule sigma functions and the schedule state type.
package sha256_pkg;

    localparam int WORDS  = 16;
    localparam int ROUNDS = 64;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        ROUND  = 2'd1,
        UPDATE = 2'd2
    } sched_state_t;

    // Round constants: fractional parts of the cube roots of the first 64 primes.
    localparam logic [31:0] K_TABLE [0:ROUNDS-1] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] H_INIT [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_msg_schedule_if.sv
// Valid/ready word stream feeding message words into the schedule.
interface sha256_msg_schedule_if;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;

    modport master (output s_valid, output s_data, input  s_ready);
    modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface

// File: rtl/sha256_k_rom.sv
// Combinational round-constant lookup indexed by the round counter.
module sha256_k_rom
    import sha256_pkg::*;
(
    input  logic [5:0]  addr,
    output logic [31:0] k
);

    assign k = K_TABLE[addr];

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads 16 words, streams W[t]/K[t] for 64 rounds, then strobes update.
// Optional SHA256_INPUT_BSWAP_EN byte-swaps each incoming word for little-endian sources.
module sha256_msg_schedule
    import sha256_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    sha256_msg_schedule_if.slave s,
    output logic [31:0]          w_out,
    output logic [31:0]          k_out,
    output logic                 enable,
    output logic                 update,
    output logic                 busy,
    output logic                 chunk_done
);

    sched_state_t             state;
    logic [$clog2(WORDS)-1:0] load_cnt;
    logic [5:0]               rnd;
    logic [31:0]              win [0:WORDS-1];

    logic [31:0] in_word;
    logic [31:0] new_word;
    logic        shift_en;
    logic [31:0] shift_in;
    logic        load_fire;

`ifdef SHA256_INPUT_BSWAP_EN
    assign in_word = {s.s_data[7:0], s.s_data[15:8], s.s_data[23:16], s.s_data[31:24]};
`else
    assign in_word = s.s_data;
`endif

    assign s.s_ready = (state == LOAD);
    assign load_fire = s.s_valid && (state == LOAD);
    assign new_word  = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];
    assign w_out     = win[0];

    always_comb begin
        shift_en = 1'b0;
        shift_in = in_word;
        if (load_fire) begin
            shift_en = 1'b1;
        end else if (state == ROUND) begin
            shift_en = 1'b1;
            shift_in = new_word;
        end
    end

    sha256_k_rom u_k_rom (
        .addr (rnd),
        .k    (k_out)
    );

    // The window serves both as the load buffer and as the W[t-16..t-1] sliding window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WORDS; i++) begin
                win[i] <= '0;
            end
        end else if (shift_en) begin
            for (int i = 0; i < WORDS - 1; i++) begin
                win[i] <= win[i + 1];
            end
            win[WORDS-1] <= shift_in;
        end
    end

    // enable drives an async clear in the compressor, so it is only ever a flop output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOAD;
            load_cnt   <= '0;
            rnd        <= '0;
            enable     <= 1'b0;
            update     <= 1'b0;
            busy       <= 1'b0;
            chunk_done <= 1'b0;
        end else begin
            chunk_done <= 1'b0;
            unique case (state)
                LOAD: begin
                    if (load_fire) begin
                        load_cnt <= load_cnt + 1'b1;
                        if (load_cnt == ($clog2(WORDS))'(WORDS - 1)) begin
                            state  <= ROUND;
                            rnd    <= '0;
                            enable <= 1'b1;
                            busy   <= 1'b1;
                        end
                    end
                end
                ROUND: begin
                    rnd <= rnd + 1'b1;
                    if (rnd == 6'(ROUNDS - 1)) begin
                        state  <= UPDATE;
                        update <= 1'b1;
                    end
                end
                UPDATE: begin
                    state      <= LOAD;
                    enable     <= 1'b0;
                    update     <= 1'b0;
                    busy       <= 1'b0;
                    chunk_done <= 1'b1;
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule using the "abc" chunk and FIPS 180-4 round constants.
module tb_sha256_msg_schedule;

    logic        clk;
    logic        rst_n;
    logic [31:0] w_out;
    logic [31:0] k_out;
    logic        enable;
    logic        update;
    logic        busy;
    logic        chunk_done;

    int vectors;
    int miscompares;
    int hs_total;

    sha256_msg_schedule_if sif ();

    sha256_msg_schedule dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s          (sif.slave),
        .w_out      (w_out),
        .k_out      (k_out),
        .enable     (enable),
        .update     (update),
        .busy       (busy),
        .chunk_done (chunk_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected W[0..19] for the padded "abc" chunk.
    logic [31:0] exp_w [0:19];
    logic [31:0] exp_k [0:63];
    logic [31:0] abc_words [16];

    initial begin
        exp_k = '{
            32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
            32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
            32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
            32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
            32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
            32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
            32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
            32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
        };
        for (int i = 0; i < 20; i++) exp_w[i] = 32'h0;
        exp_w[0]  = 32'h61626380;
        exp_w[15] = 32'h00000018;
        exp_w[16] = 32'h61626380;
        exp_w[17] = 32'h000f0000;
        exp_w[18] = 32'h7da86405;
        exp_w[19] = 32'h600003c6;
        for (int i = 0; i < 16; i++) abc_words[i] = exp_w[i];
    end

    always @(posedge clk) begin
        if (rst_n && sif.s_valid && sif.s_ready) hs_total++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // The source presents big-endian words; a byte-swapping build expects them little-endian.
    function automatic logic [31:0] srcWord(input logic [31:0] w);
`ifdef SHA256_INPUT_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    // Pushes 16 words; optionally idles s_valid between words or holds it high afterwards.
    task automatic applyStimulus(input logic [31:0] words [16], input bit gap, input bit hold_after);
        int waited;
        for (int i = 0; i < 16; i++) begin
            sif.s_data  = srcWord(words[i]);
            sif.s_valid = 1'b1;
            waited = 0;
            while (!sif.s_ready && waited < 200) begin
                @(posedge clk); #1;
                waited++;
            end
            if (waited >= 200) checkOutput("load_timeout", 32'd0, 32'd1);
            @(posedge clk); #1;
            if (gap && i < 15) begin
                sif.s_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        if (hold_after) sif.s_data = 32'hdeadbeef;
        else            sif.s_valid = 1'b0;
    endtask

    // Walks the round phase from rnd 0; stops early (rnd == abort_at) to let the caller reset.
    task automatic runRounds(input string name, input int hs_base, input int abort_at);
        int en_cycles = 0;
        int bad_ready = 0;
        int bad_update = 0;
        checkOutput({name, "_busy_round"}, {31'd0, busy}, 32'd1);
        for (int r = 0; r < 64; r++) begin
            if (r == abort_at) return;
            if (r < 20) checkOutput($sformatf("%s_w%0d", name, r), w_out, exp_w[r]);
            checkOutput($sformatf("%s_k%0d", name, r), k_out, exp_k[r]);
            if (enable) en_cycles++;
            if (sif.s_ready) bad_ready++;
            if (update) bad_update++;
            @(posedge clk); #1;
        end
        checkOutput({name, "_ready_low_rounds"}, bad_ready, 32'd0);
        checkOutput({name, "_update_low_rounds"}, bad_update, 32'd0);
        checkOutput({name, "_update_hi"}, {31'd0, update}, 32'd1);
        checkOutput({name, "_ready_low_upd"}, {31'd0, sif.s_ready}, 32'd0);
        if (enable) en_cycles++;
        sif.s_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput({name, "_enable_cycles"}, en_cycles, 32'd65);
        checkOutput({name, "_enable_low"}, {31'd0, enable}, 32'd0);
        checkOutput({name, "_update_low"}, {31'd0, update}, 32'd0);
        checkOutput({name, "_busy_low"}, {31'd0, busy}, 32'd0);
        checkOutput({name, "_chunk_done"}, {31'd0, chunk_done}, 32'd1);
        checkOutput({name, "_ready_back"}, {31'd0, sif.s_ready}, 32'd1);
        checkOutput({name, "_handshakes"}, hs_total - hs_base, 32'd16);
        @(posedge clk); #1;
        checkOutput({name, "_chunk_done_pulse"}, {31'd0, chunk_done}, 32'd0);
    endtask

    initial begin
        int base;
        vectors     = 0;
        miscompares = 0;
        hs_total    = 0;
        rst_n       = 1'b0;
        sif.s_valid = 1'b0;
        sif.s_data  = 32'h0;
        #12;
        checkOutput("rst_w_out", w_out, 32'h0);
        checkOutput("rst_k_out", k_out, 32'h428a2f98);
        checkOutput("rst_enable", {31'd0, enable}, 32'd0);
        checkOutput("rst_update", {31'd0, update}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_chunk_done", {31'd0, chunk_done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_ready", {31'd0, sif.s_ready}, 32'd1);

        $display("[TB] abc chunk, continuous valid");
        base = hs_total;
        applyStimulus(abc_words, 1'b0, 1'b0);
        runRounds("abc", base, -1);

        $display("[TB] abc chunk, valid toggling");
        base = hs_total;
        applyStimulus(abc_words, 1'b1, 1'b0);
        checkOutput("bp_handshakes_load", hs_total - base, 32'd16);
        checkOutput("bp_enable_first", {31'd0, enable}, 32'd1);
        runRounds("bp", base, -1);

        $display("[TB] valid held high through the rounds");
        base = hs_total;
        applyStimulus(abc_words, 1'b0, 1'b1);
        runRounds("hold", base, -1);
        base = hs_total;
        applyStimulus(abc_words, 1'b0, 1'b0);
        runRounds("next", base, -1);

        $display("[TB] reset at round 30");
        base = hs_total;
        applyStimulus(abc_words, 1'b0, 1'b0);
        runRounds("pre_rst", base, 30);
        checkOutput("mid_enable_before", {31'd0, enable}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_enable", {31'd0, enable}, 32'd0);
        checkOutput("mid_rst_update", {31'd0, update}, 32'd0);
        checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("mid_rst_w_out", w_out, 32'h0);
        checkOutput("mid_rst_k_out", k_out, 32'h428a2f98);
        #3;
        rst_n = 1'b1;
        #1;
        checkOutput("mid_rst_ready", {31'd0, sif.s_ready}, 32'd1);
        @(posedge clk); #1;
        base = hs_total;
        applyStimulus(abc_words, 1'b0, 1'b0);
        runRounds("reload", base, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
